// File: rtl/booth_mult_seq_if.sv
// Operand/result handshake bundle for booth_mult_seq.
// The "slave" modport is the multiplier side, and the "master" modport is the operand source / result consumer.
interface booth_mult_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] y;
  logic               busy;
  logic [1:0]         state;

  modport slave (
    input  in_valid, signed_mode, a, b, out_ready,
    output in_ready, out_valid, y, busy, state
  );

  modport master (
    output in_valid, signed_mode, a, b, out_ready,
    input  in_ready, out_valid, y, busy, state
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes on both sides.
// Supports a per-operation signed/unsigned mode, and the FSM state is exported for board debug.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  booth_mult_seq_if.slave bus
);
  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned CW = $clog2(W1 + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [W1-1:0]       r_m;
  logic [W1-1:0]       r_q;
  logic                r_qm1;
  logic [W1:0]         r_acc;
  logic [CW-1:0]       r_cnt;
  logic [2*WIDTH-1:0]  r_y;

  logic [W1-1:0]       w_a_ext;
  logic [W1-1:0]       w_b_ext;
  logic [W1:0]         w_m_ext;
  logic [W1:0]         w_sum;
  logic [W1:0]         w_acc_nx;
  logic [W1-1:0]       w_q_nx;
  logic [2*WIDTH-1:0]  w_prod;
  logic                w_accept;
  logic                w_last;

  // The extra extension bit lets unsigned operands go through the signed Booth recoding unchanged.
  assign w_a_ext  = {bus.signed_mode & bus.a[WIDTH-1], bus.a};
  assign w_b_ext  = {bus.signed_mode & bus.b[WIDTH-1], bus.b};
  assign w_m_ext  = {r_m[W1-1], r_m};
  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_state == CALC) && (r_cnt == CW'(1));

  always_comb begin
    w_sum = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_acc + w_m_ext;
      2'b10:   w_sum = r_acc - w_m_ext;
      default: w_sum = r_acc;
    endcase
  end

  assign w_acc_nx = {w_sum[W1], w_sum[W1:1]};
  assign w_q_nx   = {w_sum[0], r_q[W1-1:1]};
  // The low 2*WIDTH bits of the shifted {acc,Q} are all of Q plus the bottom WIDTH-1 bits of acc.
  assign w_prod   = {w_acc_nx[WIDTH-2:0], w_q_nx};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_nx = CALC;
      CALC:    if (w_last) w_state_nx = DONE;
      DONE:    if (bus.out_ready) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m   <= '0;
      r_q   <= '0;
      r_qm1 <= 1'b0;
      r_acc <= '0;
      r_cnt <= '0;
      r_y   <= '0;
    end else if (w_accept) begin
      r_m   <= w_a_ext;
      r_q   <= w_b_ext;
      r_qm1 <= 1'b0;
      r_acc <= '0;
      r_cnt <= CW'(W1);
    end else if (r_state == CALC) begin
      r_acc <= w_acc_nx;
      r_q   <= w_q_nx;
      r_qm1 <= r_q[0];
      r_cnt <= r_cnt - CW'(1);
      if (w_last) r_y <= w_prod;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state == CALC) || (r_state == DONE);
  assign bus.state     = r_state;
  assign bus.y         = r_y;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq at WIDTH=8 and WIDTH=16.
// It uses directed corner cases and $urandom operations, checked against an integer-arithmetic product model.
module tb_booth_mult_seq;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  booth_mult_seq_if #(.WIDTH(8))  b8  ();
  booth_mult_seq_if #(.WIDTH(16)) b16 ();

  booth_mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  booth_mult_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input int w, input bit sm,
                                          input logic [31:0] a, input logic [31:0] b);
    longint      ea;
    longint      eb;
    longint      p;
    logic [63:0] mask;
    ea = longint'(a & ((32'd1 << w) - 32'd1));
    eb = longint'(b & ((32'd1 << w) - 32'd1));
    if (sm && a[w-1]) ea = ea - (longint'(1) << w);
    if (sm && b[w-1]) eb = eb - (longint'(1) << w);
    p    = ea * eb;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  task automatic drive(input int sel, input bit v, input bit sm,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel == 0) begin
      b8.in_valid = v;  b8.signed_mode = sm;  b8.a = a[7:0];   b8.b = b[7:0];
    end else begin
      b16.in_valid = v; b16.signed_mode = sm; b16.a = a[15:0]; b16.b = b[15:0];
    end
  endtask

  task automatic set_ordy(input int sel, input bit r);
    if (sel == 0) b8.out_ready = r;
    else          b16.out_ready = r;
  endtask

  // Flags are packed as {busy, in_ready, out_valid, state[1:0]}.
  function automatic logic [4:0] flags(input int sel);
    if (sel == 0) return {b8.busy, b8.in_ready, b8.out_valid, b8.state};
    return {b16.busy, b16.in_ready, b16.out_valid, b16.state};
  endfunction

  function automatic logic [63:0] get_y(input int sel);
    if (sel == 0) return {48'd0, b8.y};
    return {32'd0, b16.y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the DUT in IDLE.
  task automatic run_op(input string tag, input int sel, input bit sm,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int hold, input bit pulse);
    int w;
    int n;
    w = (sel == 0) ? 8 : 16;
    check({tag, "_ready"}, 64'(flags(sel)), 64'(5'b01000));
    drive(sel, 1'b1, sm, a, b);
    tick();
    drive(sel, 1'b0, ~sm, $urandom, $urandom);
    n = 0;
    while (flags(sel)[2] !== 1'b1 && n < 4 * w) begin
      check({tag, "_calc"}, 64'(flags(sel)), 64'(5'b10001));
      drive(sel, 1'b0, $urandom_range(0, 1), $urandom, $urandom);
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(w + 1));
    check({tag, "_y"}, get_y(sel), exp);
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == hold / 2) drive(sel, 1'b1, sm, $urandom, $urandom);
      else                        drive(sel, 1'b0, sm, a, b);
      tick();
      check({tag, "_hold_flags"}, 64'(flags(sel)), 64'(5'b10110));
      check({tag, "_hold_y"}, get_y(sel), exp);
    end
    drive(sel, 1'b0, sm, a, b);
    set_ordy(sel, 1'b1);
    tick();
    set_ordy(sel, 1'b0);
    check({tag, "_idle"}, 64'(flags(sel)), 64'(5'b01000));
    check({tag, "_y_kept"}, get_y(sel), exp);
    if (pulse) begin
      tick();
      check({tag, "_no_accept"}, 64'(flags(sel)), 64'(5'b01000));
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rs;
    bit          saw_valid;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_ordy(0, 1'b0);
    set_ordy(1, 1'b0);

    #2 rst = 1'b1;
    #1;
    check("rst_y8", get_y(0), 64'd0);
    check("rst_flags8", 64'(flags(0)), 64'(5'b01000));
    check("rst_flags16", 64'(flags(1)), 64'(5'b01000));
    #4 rst = 1'b0;
    tick();

    run_op("s_m3x5", 0, 1'b1, 32'hFD, 32'h05, 64'hFFF1, 0, 1'b0);
    run_op("u_ffxff", 0, 1'b0, 32'hFF, 32'hFF, 64'hFE01, 2, 1'b0);
    run_op("s_ffxff", 0, 1'b1, 32'hFF, 32'hFF, 64'h0001, 1, 1'b0);
    run_op("s_80x80", 0, 1'b1, 32'h80, 32'h80, 64'h4000, 0, 1'b0);
    run_op("s_7fx80", 0, 1'b1, 32'h7F, 32'h80, 64'hC080, 0, 1'b0);
    run_op("bp_20", 0, 1'b0, 32'h12, 32'h34, 64'h03A8, 20, 1'b1);
    run_op("after_bp", 0, 1'b1, 32'h9C, 32'h3B, ref_mul(8, 1'b1, 32'h9C, 32'h3B), 0, 1'b0);
    run_op("a_zero", 0, 1'b1, 32'h00, 32'hA5, 64'h0000, 0, 1'b0);
    run_op("b_zero", 0, 1'b0, 32'hC3, 32'h00, 64'h0000, 0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      run_op("rand8", 0, rs, ra, rb, ref_mul(8, rs, ra, rb), $urandom_range(0, 3), 1'b0);
    end

    run_op("pre_rst", 0, 1'b0, 32'h21, 32'h03, 64'h0063, 0, 1'b0);
    drive(0, 1'b1, 1'b1, 32'h55, 32'hAA);
    tick();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_y", get_y(0), 64'd0);
    check("midrst_flags", 64'(flags(0)), 64'(5'b01000));
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (flags(0)[2] !== 1'b0) saw_valid = 1'b1;
    end
    check("midrst_no_valid", 64'(saw_valid), 64'd0);
    run_op("u_7x6", 0, 1'b0, 32'd7, 32'd6, 64'h002A, 0, 1'b0);

    run_op("s16_8000x2", 1, 1'b1, 32'h8000, 32'h0002, 64'hFFFF0000, 0, 1'b0);
    run_op("u16_max", 1, 1'b0, 32'hFFFF, 32'hFFFF, 64'hFFFE0001, 1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      run_op("rand16", 1, rs, ra, rb, ref_mul(16, rs, ra, rb), $urandom_range(0, 2), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier: next generation of the team's fixed 8-bit Booth datapath/FSM pair.
- Generalised to WIDTH-bit operands, with a per-operation signed/unsigned mode.
- Adds a valid/ready handshake on both input and output, so it can sit between a stimulus source (switches/UART/CPU register) and a result consumer (display driver) without the consumer needing to poll.
- Controller and datapath live in one module; the FSM state is exported for board debug.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair a/b/signed_mode is valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- signed_mode  in  1  1 = two's-complement operands; 0 = unsigned operands. Sampled on accept.
- a  in  WIDTH  multiplicand, sampled on accept.
- b  in  WIDTH  multiplier, sampled on accept.
- out_valid  out  1  y holds a completed product.
- out_ready  in  1  consumer takes product.
- y  out  2*WIDTH  product; registered, held stable while out_valid=1.
- busy  out  1  high in CALC or DONE.
- state  out  2  FSM state encoding: IDLE=0, CALC=1, DONE=2.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, y=0, out_valid=0, busy=0, in_ready=1.
  - Internal acc, Q, Q_-1 and count cleared; any operation in flight is discarded.
- Internal widths:
  - W1 = WIDTH+1.
  - Operands are extended to W1 bits: sign-extended if signed_mode=1, zero-extended if 0.
  - M (multiplicand register): W1 bits. Q (multiplier register): W1 bits. Q_-1: 1 bit.
  - acc: W1+1 bits, which guarantees no intermediate overflow.
  - count: clog2(W1+1) bits.
- Accept: in IDLE, if in_valid=1 on a clock edge:
  - M <= ext(a), Q <= ext(b), Q_-1 <= 0, acc <= 0, count <= W1.
  - Go to CALC.
- CALC, one Booth iteration per clock:
  - {Q[0],Q_-1}=01 -> acc+=ext(M). 10 -> acc-=ext(M). 00 or 11 -> no add.
  - Then arithmetic right shift of {acc,Q,Q_-1} by 1; acc MSB replicates.
  - count decrements each iteration.
  - On the edge where count==1, the final iteration completes and y <= low 2*WIDTH bits of the resulting {acc,Q}. The same edge sets state=DONE and out_valid=1.
- Latency: out_valid rises exactly W1 = WIDTH+1 clock edges after the accepting edge (9 for WIDTH=8).
- DONE:
  - out_valid=1 and y held until an edge with out_ready=1; then out_valid=0 and state=IDLE.
  - There is no same-cycle bypass: the next accept can occur no earlier than the edge after the return to IDLE.
- Handshake rules:
  - in_ready = (state==IDLE), combinational from state.
  - in_valid is ignored in CALC and DONE. Operand changes during CALC do not affect the result.
  - y retains the last product after the return to IDLE, until the next result write or reset.
- Arithmetic:
  - Signed mode: exact two's-complement product, including the case where both operands are the most negative value.
  - Unsigned mode: exact unsigned product; all-ones × all-ones is correct thanks to the extra extension bit.
- Boundary cases:
  - a=0 or b=0 gives y=0 with the same fixed latency.
  - The result never overflows 2*WIDTH bits.

Test Plan:
- WIDTH=8, rst pulsed asynchronously with no clock edge -> y=0x0000, in_ready=1, out_valid=0, state=0 immediately.
- WIDTH=8, signed a=0xFD(-3), b=0x05 -> out_valid exactly 9 edges after accept; y=0xFFF1 (-15); busy high throughout.
- WIDTH=8, unsigned a=0xFF, b=0xFF -> y=0xFE01. Same operands in signed mode (-1×-1) -> y=0x0001.
- WIDTH=8, signed a=0x80, b=0x80 -> y=0x4000. Signed a=0x7F, b=0x80 -> y=0xC080.
- Backpressure: hold out_ready=0 for 20 cycles after completion -> out_valid and y stable, in_ready=0, and an in_valid pulse in that window is not accepted. Then assert out_ready for 1 cycle -> IDLE next edge; a new accept is possible one edge later.
- Reset mid-CALC (after 4 iterations) -> IDLE, y=0 immediately, no out_valid afterwards. Then a new op 7×6 unsigned -> y=0x002A. Repeat with WIDTH=16 signed 0x8000×0x0002 -> y=0xFFFF0000.
